wifi_fifo_frame_reader: RTL and testbench



---
 rtl/wifi_fifo_frame_reader_pkg.sv | 16 +
 rtl/wifi_fifo_frame_reader_if.sv | 41 ++++
 rtl/wifi_fifo_frame_reader_skid_buf.sv | 52 +++++
 rtl/wifi_fifo_frame_reader.sv | 142 ++++++++++++++
 tb/tb_wifi_fifo_frame_reader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wifi_fifo_frame_reader_pkg.sv
// Shared types and constants for the WiFi TX FIFO frame reader.
// Optional m_last output is enabled by WIFI_FRAME_LAST_EN.
package wifi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rd_state_e;

  localparam int BUF_DEPTH  = 2;
  localparam int SIZE_W_DEF = 16;
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W      = $clog2(BUF_DEPTH);

endpackage

// File: rtl/wifi_fifo_frame_reader_if.sv
// Valid/ready stream from the frame reader to the PHY modulator.
// m_last exists only when WIFI_FRAME_LAST_EN is defined.
interface wifi_fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

`ifdef WIFI_FRAME_LAST_EN
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
`else
  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
`endif

endinterface

// File: rtl/wifi_fifo_frame_reader_skid_buf.sv
// Two-entry buffer absorbing the FIFO RAM read latency.
// Head entry holds still until popped; flush drops all entries.
module wifi_rd_skid_buf
  import wifi_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occupancy,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  not_empty
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign occupancy = cnt;
  assign head      = mem[rd_ptr];
  assign not_empty = (cnt != '0);

endmodule

// File: rtl/wifi_fifo_frame_reader.sv
// Drains one frame of data_size words from the TX FIFO into the PHY stream.
// Define WIFI_FRAME_LAST_EN to add m_last on the final word of a frame.
module wifi_fifo_frame_reader
  import wifi_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_FIFO  = 8,
  parameter int SIZE_W     = SIZE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] data_size,
  input  logic                  fifo_empty,
  output logic                  fifo_r_inc,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  wifi_fifo_frame_reader_if.master m,
  output logic                  busy,
  output logic                  tx_irq,
  output logic [SIZE_W-1:0]     words_sent
);

  localparam int LOAD_W = ADDR_FIFO + 1;

  rd_state_e             state_q;
  rd_state_e             state_d;
  logic [SIZE_W-1:0]     size_q;
  logic [SIZE_W-1:0]     issued_q;
  logic [SIZE_W-1:0]     sent_q;
  logic [SIZE_W-1:0]     sent_d;
  logic [SIZE_W-1:0]     start_size;
  logic [ADDR_FIFO-1:0]  inflight_q;
  logic [OCC_W-1:0]      occ;
  logic [LOAD_W-1:0]     load;
  logic [DATA_WIDTH-1:0] head;
  logic                  buf_ne;
  logic                  xfer;
  logic                  go;
  logic                  flush;
  logic                  rd_issue;

  assign start_size = data_size[SIZE_W-1:0];

  if (DATA_WIDTH > SIZE_W) begin : g_size_hi
    logic unused_size_hi;
    assign unused_size_hi = ^data_size[DATA_WIDTH-1:SIZE_W];
  end

  assign go     = (state_q == IDLE) && start && !abort;
  assign flush  = (state_q == RUN) && abort;
  assign xfer   = buf_ne && m.m_ready;
  assign sent_d = sent_q + SIZE_W'(xfer);

  // A pop this cycle frees a slot, keeping one word per cycle.
  assign load = LOAD_W'(occ)
              + LOAD_W'(inflight_q)
              - LOAD_W'(xfer);

  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (start_size == '0) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            rd_issue = !fifo_empty;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rd_issue = !fifo_empty
                  && (issued_q < size_q)
                  && (load < LOAD_W'(BUF_DEPTH));
          if (sent_d == size_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      size_q     <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= ADDR_FIFO'(rd_issue);
      if (go) begin
        size_q   <= start_size;
        issued_q <= SIZE_W'(rd_issue);
        sent_q   <= '0;
      end else if (state_q == RUN && !abort) begin
        issued_q <= issued_q + SIZE_W'(rd_issue);
        sent_q   <= sent_d;
      end
    end
  end

  // A word landing during the abort cycle is dropped by the flush.
  wifi_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (CLK),
    .rst       (RST),
    .flush     (flush),
    .push      (|inflight_q),
    .push_data (fifo_r_data),
    .pop       (xfer),
    .occupancy (occ),
    .head      (head),
    .not_empty (buf_ne)
  );

  assign fifo_r_inc = rd_issue;
  assign m.m_valid  = buf_ne;
  assign m.m_data   = head;
  assign busy       = (state_q != IDLE);
  assign tx_irq     = (state_q == DONE);
  assign words_sent = sent_q;

`ifdef WIFI_FRAME_LAST_EN
  assign m.m_last = buf_ne && (sent_q == size_q - SIZE_W'(1));
`endif

endmodule

// File: tb/tb_wifi_fifo_frame_reader.sv
// Randomized bench for wifi_fifo_frame_reader against a queue-based model.
// Honours WIFI_FRAME_LAST_EN when checking m_last.
module tb_wifi_fifo_frame_reader;

  localparam int DW = 32;
  localparam int SW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] data_size = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_r_inc;
  logic [DW-1:0] fifo_r_data = '0;
  logic          busy;
  logic          tx_irq;
  logic [SW-1:0] words_sent;

  wifi_fifo_frame_reader_if #(.DATA_WIDTH(DW)) strm ();

  wifi_fifo_frame_reader #(
    .DATA_WIDTH (DW),
    .ADDR_FIFO  (8),
    .SIZE_W     (SW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .abort       (abort),
    .data_size   (data_size),
    .fifo_empty  (fifo_empty),
    .fifo_r_inc  (fifo_r_inc),
    .fifo_r_data (fifo_r_data),
    .m           (strm),
    .busy        (busy),
    .tx_irq      (tx_irq),
    .words_sent  (words_sent)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // model state
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  int cyc = 0, start_cyc = 0, mode = 0, fsize = 0, pre = 0;
  int outst = 0, n_rd = 0, n_xfer = 0;
  int irq_n = 0, irq_cyc = -1, ws_irq = 0;
  int lastx_cyc = -1, first_v = -1, busy_n = 0;
  int force_cnt = 0, win_stall = 0;
  logic hold = 1'b0, abort_prev = 1'b0, rd_pend = 1'b0;
  logic [DW-1:0] hold_d = '0;

  function automatic logic ready_now();
    int ph;
    ph = (cyc - start_cyc) & 3;
    case (mode)
      0:       return 1'b1;
      1:       return (ph == 0) || (ph == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic tick();
    logic rd, xf;
    @(negedge CLK);
    rd = fifo_r_inc;
    xf = strm.m_valid && strm.m_ready;
    if (rd) begin
      check("rd_not_empty", fifo_empty, 0);
      check("rd_credit", (outst - int'(xf)) < 2, 1);
      n_rd++;
    end
    if (hold && !abort_prev) begin
      check("hold_valid", strm.m_valid, 1);
      check("hold_data", strm.m_data, hold_d);
    end
`ifdef WIFI_FRAME_LAST_EN
    check("m_last", strm.m_last,
          strm.m_valid && (n_xfer == fsize - 1));
`endif
    if (xf) begin
      if (exp_q.size() == 0) check("extra_word", n_xfer + 1, fsize);
      else check("m_data", strm.m_data, exp_q.pop_front());
      check("words_sent", words_sent, n_xfer);
      n_xfer++;
      lastx_cyc = cyc;
    end
    if (strm.m_valid && first_v < 0) first_v = cyc;
    if (tx_irq) begin
      irq_n++;
      irq_cyc = cyc;
      ws_irq  = int'(words_sent);
    end
    if (busy) busy_n++;
    if (force_cnt > 0 && !strm.m_valid) win_stall++;
    hold       = strm.m_valid && !strm.m_ready;
    hold_d     = strm.m_data;
    abort_prev = abort;
    outst      = abort ? 0 : outst + int'(rd) - int'(xf);
    rd_pend    = rd && !fifo_empty;
    @(posedge CLK);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    fifo_r_data = rd_pend ? fifo_q.pop_front() : DW'($urandom);
    if (force_cnt > 0) force_cnt--;
    fifo_empty = (fifo_q.size() == 0) || (force_cnt > 0);
    strm.m_ready = ready_now();
  endtask

  task automatic setup(input int sz, input int md);
    logic [DW-1:0] w;
    fifo_q.delete();
    exp_q.delete();
    pre = sz + 2;
    for (int i = 0; i < pre; i++) begin
      w = DW'($urandom);
      fifo_q.push_back(w);
      if (i < sz) exp_q.push_back(w);
    end
    fifo_empty = 1'b0;
    mode = md; fsize = sz;
    n_rd = 0; n_xfer = 0; irq_n = 0; irq_cyc = -1;
    lastx_cyc = -1; first_v = -1; busy_n = 0;
    win_stall = 0; outst = 0;
    start_cyc = cyc;
    strm.m_ready = ready_now();
    data_size = {16'($urandom), 16'(sz)};
    start = 1'b1;
  endtask

  task automatic frame(input int sz, input int md, input int emp_at,
                       input int abort_at, input bit bpulse);
    bit aborted = 0, win_done = 0;
    int ab_cyc = -1;
    setup(sz, md);
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (bpulse && cyc == start_cyc + 3) begin
        start = 1'b1;
        data_size = 32'd3;
      end
      if (emp_at >= 0 && !win_done && n_xfer == emp_at) begin
        win_done = 1;
        force_cnt = 5;
        fifo_empty = 1'b1;
      end
      if (abort_at >= 0 && !aborted && n_xfer >= abort_at) begin
        aborted = 1;
        abort = 1'b1;
        ab_cyc = cyc;
      end else if (aborted && cyc == ab_cyc + 1) begin
        check("abort_valid", strm.m_valid, 0);
        check("abort_busy", busy, 0);
      end
      if (aborted && cyc > ab_cyc + 4) break;
      if (irq_n > 0 && cyc > irq_cyc + 2) break;
    end
    if (abort_at >= 0) begin
      check("abort_seen", aborted, 1);
      check("abort_irq", irq_n, 0);
    end else begin
      check("irq_count", irq_n, 1);
      check("xfers", n_xfer, sz);
      check("rd_count", n_rd, sz);
      check("irq_words", ws_irq, sz);
      check("busy_cycles", busy_n, irq_cyc - start_cyc);
      check("irq_time", irq_cyc,
            (sz == 0) ? start_cyc + 1 : lastx_cyc + 1);
      if (sz > 0) check("first_valid", first_v, start_cyc + 2);
      check("fifo_left", fifo_q.size(), pre - sz);
      if (emp_at >= 0) check("empty_stall", win_stall > 0, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    strm.m_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_irq", tx_irq, 0);
    check("rst_rinc", fifo_r_inc, 0);
    check("rst_valid", strm.m_valid, 0);
    check("rst_data", strm.m_data, 0);
    check("rst_words", words_sent, 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    frame(4, 0, -1, -1, 0);
    frame(8, 1, -1, -1, 0);
    frame(6, 0, 3, -1, 0);
    frame(0, 0, -1, -1, 0);
    frame(10, 0, -1, 3, 0);
    frame(2, 0, -1, -1, 0);
    frame(5, 2, -1, -1, 1);

    n_rd = 0;
    abort = 1'b1;
    tick();
    check("idle_abort_busy", busy, 0);
    start = 1'b1;
    abort = 1'b1;
    data_size = 32'd4;
    tick();
    check("start_abort_busy", busy, 0);
    check("start_abort_rd", n_rd, 0);

    for (int f = 0; f < 8; f++) begin
      int sz;
      sz = $urandom_range(1, 20);
      frame(sz, $urandom_range(0, 2), -1, -1, sz >= 5);
    end

    setup(8, 0);
    repeat (4) tick();
    check("pre_rst_valid", strm.m_valid, 1);
    check("pre_rst_busy", busy, 1);
    #1 RST = 1'b1;
    #2;
    check("arst_valid", strm.m_valid, 0);
    check("arst_data", strm.m_data, 0);
    check("arst_busy", busy, 0);
    check("arst_irq", tx_irq, 0);
    check("arst_words", words_sent, 0);
    check("arst_rinc", fifo_r_inc, 0);
`ifdef WIFI_FRAME_LAST_EN
    check("arst_last", strm.m_last, 0);
`endif
    @(posedge CLK);
    #1;
    RST = 1'b0;
    hold = 1'b0;
    abort_prev = 1'b0;
    outst = 0;
    frame(3, 0, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
